pattern_input_capture: RTL and testbench

Parametrised successor to the single-bit serial input handler in the memory game. Captures a player's guess as a sequence of multi-bit button symbols. Each press is edge-qualified. Capture length is set per round from the score counter, and an inactivity timeout and an abort are supported. Sits between the button debouncers and the comparator, and reports completion to the game-mode FSM.

---
 rtl/mem_pkg.sv | 15 +
 rtl/pattern_input_capture_press_edge_detect.sv | 18 +
 rtl/pattern_input_capture.sv | 93 +++++++++
 tb/tb_pattern_input_capture.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default sizing for the memory game datapath
// (input capture, comparator, classic mode).
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE,
    TOUT
  } cap_state_t;

  localparam int DEF_SYM_W   = 2;
  localparam int DEF_MAX_LEN = 16;

endpackage

// File: rtl/pattern_input_capture_press_edge_detect.sv
// Rising-edge qualifier for a debounced button level; one strobe per press.
module press_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_strobe
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= i_level;
  end

  assign o_strobe = i_level & ~r_prev;

endmodule

// File: rtl/pattern_input_capture.sv
// Captures a player's guess as a sequence of edge-qualified button symbols,
// with per-round length, inactivity timeout and abort.
module pattern_input_capture
  import mem_pkg::*;
#(
  parameter int SYM_W       = DEF_SYM_W,
  parameter int MAX_LEN     = DEF_MAX_LEN,
  parameter int LEN_W       = $clog2(MAX_LEN + 1),
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic [LEN_W-1:0]         target_len,
  input  logic                     abort,
  input  logic                     sym_valid,
  input  logic [SYM_W-1:0]         sym,
  output logic                     busy,
  output logic                     received_input,
  output logic                     timed_out,
  output logic [LEN_W-1:0]         sym_count,
  output logic [MAX_LEN*SYM_W-1:0] user_guess
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYC);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 2);
  localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MAX_LEN);

  cap_state_t               r_state;
  logic [LEN_W-1:0]         r_len;
  logic [LEN_W-1:0]         r_sym_count;
  logic [MAX_LEN*SYM_W-1:0] r_user_guess;
  logic [IDLE_W-1:0]        r_idle;

  logic             w_accept;
  logic [LEN_W-1:0] w_len;
  logic [LEN_W-1:0] w_count_inc;

  press_edge_detect u_press (
    .clk      (clk),
    .rst      (rst),
    .i_level  (sym_valid),
    .o_strobe (w_accept)
  );

  assign w_len       = (target_len > LEN_MAX) ? LEN_MAX : target_len;
  assign w_count_inc = r_sym_count + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_sym_count  <= '0;
      r_user_guess <= '0;
      r_idle       <= '0;
    end else if (abort) begin
      r_state <= IDLE;
    end else if (arm) begin
      r_len        <= w_len;
      r_sym_count  <= '0;
      r_user_guess <= '0;
      r_idle       <= '0;
      r_state      <= (w_len == '0) ? DONE : CAPTURE;
    end else begin
      unique case (r_state)
        CAPTURE: begin
          if (w_accept) begin
            // Slot select by loop keeps the write index in range for any MAX_LEN.
            for (int unsigned k = 0; k < MAX_LEN; k++) begin
              if (r_sym_count == LEN_W'(k)) r_user_guess[k*SYM_W +: SYM_W] <= sym;
            end
            r_sym_count <= w_count_inc;
            r_idle      <= '0;
            if (w_count_inc == r_len) r_state <= DONE;
          end else begin
            if (r_idle != '1) r_idle <= r_idle + IDLE_W'(1);
            if (r_idle == IDLE_LAST) r_state <= TOUT;
          end
        end
        DONE:    r_state <= IDLE;
        TOUT:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy           = (r_state == CAPTURE);
  assign received_input = (r_state == DONE);
  assign timed_out      = (r_state == TOUT);
  assign sym_count      = r_sym_count;
  assign user_guess     = r_user_guess;

endmodule

// File: tb/tb_pattern_input_capture.sv
// Directed + randomized bench for pattern_input_capture against a
// queue-based model of the guess capture rules.
module tb_pattern_input_capture;

  localparam int SYM_W   = 2;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int TOUT_C  = 20;

  logic                     clk = 1'b0;
  logic                     rst, arm, abort, sym_valid;
  logic [LEN_W-1:0]         target_len;
  logic [SYM_W-1:0]         sym;
  logic                     busy, received_input, timed_out;
  logic [LEN_W-1:0]         sym_count;
  logic [MAX_LEN*SYM_W-1:0] user_guess;

  pattern_input_capture #(
    .SYM_W       (SYM_W),
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TOUT_C)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .arm            (arm),
    .target_len     (target_len),
    .abort          (abort),
    .sym_valid      (sym_valid),
    .sym            (sym),
    .busy           (busy),
    .received_input (received_input),
    .timed_out      (timed_out),
    .sym_count      (sym_count),
    .user_guess     (user_guess)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0, failed = 0;
  int n_done = 0, n_to = 0;

  // Reference model: symbols collected so far, whether a guess is open,
  // which pulse is due this cycle, and idle cycles since the last event.
  logic [SYM_W-1:0] got[$];
  bit m_open, m_done, m_to, m_prev;
  int m_len, m_idle;

  function automatic logic [MAX_LEN*SYM_W-1:0] packed_guess();
    logic [MAX_LEN*SYM_W-1:0] v = '0;
    foreach (got[k]) v[k*SYM_W +: SYM_W] = got[k];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit a, input int tl, input bit ab,
                            input bit sv, input logic [SYM_W-1:0] s);
    bit pressed = sv && !m_prev;
    m_prev = sv;
    if (r) begin
      m_open = 0; m_done = 0; m_to = 0; m_prev = 0; m_idle = 0;
      got.delete();
      return;
    end
    m_done = 0;
    m_to   = 0;
    if (ab) begin
      m_open = 0;
    end else if (a) begin
      got.delete();
      m_idle = 0;
      m_len  = (tl > MAX_LEN) ? MAX_LEN : tl;
      m_open = (m_len != 0);
      m_done = (m_len == 0);
    end else if (m_open) begin
      if (pressed) begin
        got.push_back(s);
        m_idle = 0;
        if (got.size() == m_len) begin m_open = 0; m_done = 1; end
      end else begin
        m_idle++;
        if (m_idle == TOUT_C - 1) begin m_open = 0; m_to = 1; end
      end
    end
  endtask

  task automatic step(input bit r, input bit a, input int tl, input bit ab,
                      input bit sv, input logic [SYM_W-1:0] s);
    rst = r; arm = a; target_len = LEN_W'(tl); abort = ab; sym_valid = sv; sym = s;
    @(posedge clk);
    model_edge(r, a, tl, ab, sv, s);
    #1;
    if (received_input === 1'b1) n_done++;
    if (timed_out === 1'b1) n_to++;
    chk("busy",  32'(busy),           32'(m_open));
    chk("done",  32'(received_input), 32'(m_done));
    chk("tout",  32'(timed_out),      32'(m_to));
    chk("count", 32'(sym_count),      32'(got.size()));
    chk("guess", 32'(user_guess),     32'(packed_guess()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0);
  endtask

  task automatic press(input logic [SYM_W-1:0] s, input int gap);
    step(0, 0, 0, 0, 1, s);
    idle(gap);
  endtask

  initial begin
    logic [SYM_W-1:0] seq1[5];
    int d0, t0;
    seq1 = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd2};
    rst = 1; arm = 0; abort = 0; sym_valid = 0; sym = '0; target_len = '0;
    m_open = 0; m_done = 0; m_to = 0; m_prev = 0; m_idle = 0; m_len = 0;

    step(1, 0, 0, 0, 0, '0);
    step(1, 0, 0, 0, 0, '0);
    chk("rst_outputs", {busy, received_input, timed_out, 4'(sym_count)}, '0);
    chk("rst_guess", 32'(user_guess), 0);
    idle(2);

    // 1: full guess of five symbols
    d0 = n_done;
    step(0, 1, 5, 0, 0, '0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 1, seq1[i]);
      if (i == 4) begin
        chk("t1_pulse_lat", 32'(received_input), 1);
        chk("t1_busy_fall", 32'(busy), 0);
      end
      idle(3);
    end
    chk("t1_pulses", n_done - d0, 1);
    chk("t1_guess", 32'(user_guess), 32'b10_00_11_01_10);
    chk("t1_count", 32'(sym_count), 5);

    // 2: held press counts once
    d0 = n_done;
    step(0, 1, 2, 0, 0, '0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 2'd3);
    idle(1);
    step(0, 0, 0, 0, 1, 2'd1);
    idle(2);
    chk("t2_guess", 32'(user_guess), 32'b01_11);
    chk("t2_pulses", n_done - d0, 1);
    chk("t2_count", 32'(sym_count), 2);

    // 3: inactivity timeout
    d0 = n_done; t0 = n_to;
    step(0, 1, 3, 0, 0, '0);
    step(0, 0, 0, 0, 1, 2'd2);
    idle(19);
    chk("t3_tout_now", 32'(timed_out), 1);
    idle(2);
    chk("t3_tpulses", n_to - t0, 1);
    chk("t3_no_done", n_done - d0, 0);
    chk("t3_count", 32'(sym_count), 1);
    chk("t3_guess", 32'(user_guess[1:0]), 2);

    // 4: zero-length and clamped length
    step(0, 1, 0, 0, 0, '0);
    chk("t4_zero_len", 32'(received_input), 1);
    idle(1);
    d0 = n_done;
    step(0, 1, 12, 0, 0, '0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 1, 2'(i));
      if (i == 6) chk("t4_still_busy", 32'(busy), 1);
      idle(1);
    end
    chk("t4_clamp_pulses", n_done - d0, 1);
    chk("t4_clamp_count", 32'(sym_count), 8);

    // 5: abort, then re-arm mid-capture
    d0 = n_done;
    step(0, 1, 4, 0, 0, '0);
    press(2'd1, 1);
    press(2'd2, 1);
    step(0, 0, 0, 1, 0, '0);
    chk("t5_abort_busy", 32'(busy), 0);
    idle(3);
    chk("t5_abort_nopulse", n_done - d0, 0);
    step(0, 1, 3, 0, 0, '0);
    press(2'd3, 1);
    press(2'd3, 1);
    step(0, 1, 2, 0, 0, '0);
    chk("t5_rearm_count", 32'(sym_count), 0);
    chk("t5_rearm_guess", 32'(user_guess), 0);
    press(2'd2, 1);
    press(2'd1, 2);
    chk("t5_rearm_pulses", n_done - d0, 1);
    chk("t5_rearm_guess2", 32'(user_guess), 32'b01_10);

    // 6: reset mid-capture
    step(0, 1, 4, 0, 0, '0);
    press(2'd3, 1);
    step(1, 0, 0, 0, 0, '0);
    chk("t6_rst_all", {busy, received_input, timed_out, 4'(sym_count), user_guess}, '0);
    press(2'd1, 1);
    press(2'd2, 1);
    chk("t6_ignored", 32'(sym_count), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit r, a, ab, sv;
      r  = ($urandom_range(0, 149) == 0);
      a  = ($urandom_range(0, 24) == 0);
      ab = ($urandom_range(0, 59) == 0);
      sv = (i % 40 < 30) ? ($urandom_range(0, 2) == 0) : 1'b0;
      step(r, a, $urandom_range(0, 12), ab, sv, 2'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
